adder_share_arbiter: RTL and testbench
======================================

Name: adder_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one external 32-bit Adder (operands a/b in, sum/carry out) among NUM_REQ requesters, e.g. PC+4, branch-target and ALU address paths.
- Accepts one request at a time over a valid/ready handshake, drives the shared adder's operands from registers, captures the sum and carry, and returns them tagged with the requester id.
- Sits between the datapath requesters and the single Adder instance in the KGP-RISC core.

Parameters:
- WIDTH, 32, operand/sum width; matches the adder.
- NUM_REQ, 3, number of requesters; legal range 2..8.
- ID_W, 2, width of rsp_id; must equal ceil(log2(NUM_REQ)).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; at most one bit is high at a time.
- req_a  input  NUM_REQ*WIDTH  flattened operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  input  NUM_REQ*WIDTH  flattened operand B; same packing as req_a.
- adder_a  output  WIDTH  operand A to the shared Adder.
- adder_b  output  WIDTH  operand B to the shared Adder.
- adder_sum  input  WIDTH  sum returned by the Adder (combinational).
- adder_carry  input  1  carry-out returned by the Adder.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accepts the result.
- rsp_id  output  ID_W  index of the requester that owns the result.
- rsp_sum  output  WIDTH  registered sum.
- rsp_carry  output  1  registered unsigned carry-out of bit WIDTH-1.

Behaviour:
- Reset values:
  - State = IDLE; all outputs 0.
  - adder_a = adder_b = 0; rsp_id = 0.
  - last_grant = NUM_REQ-1, so requester 0 has top priority after reset.
- FSM has three states: IDLE, EXEC, RESP.
- Arbitration:
  - Winner is the first i with req_valid[i]=1, scanning from (last_grant+1) mod NUM_REQ upward with wrap.
  - Arbitration is combinational; req_ready[winner] is asserted in the same cycle.
  - A request is accepted in a cycle with req_valid[i] & req_ready[i].
- Accept window: req_ready is driven only in IDLE, or in RESP when rsp_ready=1 (back-to-back); otherwise it is all zero.
- On accept edge:
  - Latch req_a/req_b slice of the winner into adder_a/adder_b.
  - Set the id register and last_grant to the winner.
  - Go to EXEC.
- EXEC, exactly one cycle:
  - adder_a/adder_b are held stable.
  - At the edge, capture rsp_sum <= adder_sum, rsp_carry <= adder_carry, rsp_id <= id, rsp_valid <= 1.
  - Go to RESP.
- RESP:
  - rsp_valid and rsp_* are held until rsp_ready=1.
  - With rsp_ready=1 and a new request accepted the same cycle: go to EXEC; rsp_valid drops for exactly one cycle.
  - With rsp_ready=1 and no request: go to IDLE; rsp_valid <= 0.
- Latency and throughput:
  - Request accepted at edge N gives rsp_valid=1 after edge N+1.
  - Sustained throughput is one result per 2 cycles.
- adder_a/adder_b keep their last values outside EXEC; they are never cleared except by reset.
- Arithmetic is pure unsigned WIDTH-bit addition; the sum wraps mod 2^WIDTH and the carry reports the wrap.
- Requesters must hold req_valid, req_a and req_b stable until accepted; the arbiter never drops a pending valid.
- Simultaneous requests: exactly one grant per accept; losers remain pending. Fairness: a continuously requesting requester is granted within NUM_REQ accepts.
- rst_n falling mid-operation immediately clears state and outputs; the in-flight operation is discarded and no response is produced.
- req_valid bits with index >= NUM_REQ do not exist; an out-of-range NUM_REQ is a configuration error, not checked in RTL.

Optional Feature:
- Macro: ADDER_ARB_OVF_EN.
- When defined:
  - Adds output rsp_ovf (1 bit), registered with rsp_sum in EXEC.
  - rsp_ovf = 1 when adder_a[W-1] == adder_b[W-1] and adder_sum[W-1] differs from them (two's-complement signed overflow).
  - Reset value 0; held in RESP like the other rsp_* outputs.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then req_valid=3'b001 with a=5, b=7 → req_ready[0]=1 the same cycle; two edges later rsp_valid=1, rsp_sum=12, rsp_carry=0, rsp_id=0.
- a=32'hFFFF_FFFF, b=1 from requester 2 → rsp_sum=0, rsp_carry=1, rsp_id=2; with ADDER_ARB_OVF_EN, a=32'h7FFF_FFFF, b=1 → rsp_ovf=1.
- All three requesters valid continuously, rsp_ready=1 → grant order 0,1,2,0,1,2; one rsp_valid every 2 cycles.
- Result pending with rsp_ready=0 for 5 cycles → rsp_* stable, req_ready=0, pending requester 1 is not accepted; release rsp_ready → requester 1 is accepted that same cycle.
- Assert rst_n=0 during EXEC → all outputs 0 immediately; after release, no stale response appears and requester 0 has priority.
- Requester 1 holds valid while requester 0 re-requests after every grant → requester 1 is granted no later than the second accept.

Source files
------------

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one external adder among NUM_REQ requesters.
// Optional macro ADDER_ARB_OVF_EN adds a registered signed-overflow flag (rsp_ovf).
module adder_share_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 3,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]         adder_a,
  output logic [WIDTH-1:0]         adder_b,
  input  logic [WIDTH-1:0]         adder_sum,
  input  logic                     adder_carry,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_carry
`ifdef ADDER_ARB_OVF_EN
  , output logic                   rsp_ovf
`endif
);

  // state | meaning
  // IDLE  | no operation in flight, accepting requests
  // EXEC  | operands on the adder, result captured at the end of this cycle
  // RESP  | result presented, waiting for rsp_ready
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state, state_next;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] id;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] cand;
  logic            found;
  logic            window;
  logic            accept;
  int              idx;

  // Scan starts just past the last winner, so the previous owner has lowest priority.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx  = (int'(last_grant) + k) % NUM_REQ;
      cand = ID_W'(idx);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign window = (state == IDLE) || ((state == RESP) && rsp_ready);
  assign accept = window && found;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[winner] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = accept ? EXEC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adder_a    <= '0;
      adder_b    <= '0;
      id         <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
    end else if (accept) begin
      adder_a    <= req_a[int'(winner)*WIDTH +: WIDTH];
      adder_b    <= req_b[int'(winner)*WIDTH +: WIDTH];
      id         <= winner;
      last_grant <= winner;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_carry <= 1'b0;
    end else if (state == EXEC) begin
      rsp_valid <= 1'b1;
      rsp_id    <= id;
      rsp_sum   <= adder_sum;
      rsp_carry <= adder_carry;
    end else if ((state == RESP) && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef ADDER_ARB_OVF_EN
  logic ovf_next;
  // Signed overflow: operands agree in sign but the sum does not.
  assign ovf_next = (adder_a[WIDTH-1] == adder_b[WIDTH-1]) &&
                    (adder_sum[WIDTH-1] != adder_a[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              rsp_ovf <= 1'b0;
    else if (state == EXEC)  rsp_ovf <= ovf_next;
  end
`endif

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed self-checking bench for adder_share_arbiter with a behavioural adder.
// Also checks rsp_ovf when built with ADDER_ARB_OVF_EN.
module tb_adder_share_arbiter;
  localparam int WIDTH = 32;
  localparam int NREQ  = 3;
  localparam int ID_W  = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [WIDTH-1:0]      adder_a;
  logic [WIDTH-1:0]      adder_b;
  logic [WIDTH-1:0]      adder_sum;
  logic                  adder_carry;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_carry;
`ifdef ADDER_ARB_OVF_EN
  logic                  rsp_ovf;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign {adder_carry, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b};

  adder_share_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NREQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .adder_a(adder_a), .adder_b(adder_b),
    .adder_sum(adder_sum), .adder_carry(adder_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_carry(rsp_carry)
`ifdef ADDER_ARB_OVF_EN
    , .rsp_ovf(rsp_ovf)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] oh(input int i);
    oh = NREQ'(1) << i;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  // One isolated request from requester i, result drained afterwards.
  task automatic single(input string tag, input int i, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] es,
                        input logic ec, input logic eo);
    set_op(i, a, b);
    req_valid = oh(i);
    rsp_ready = 1'b0;
    #1 check({tag, "_ready"}, 64'(req_ready), 64'(oh(i)));
    step();
    req_valid = '0;
    check({tag, "_exec_valid"}, 64'(rsp_valid), 64'(0));
    step();
    check({tag, "_valid"}, 64'(rsp_valid), 64'(1));
    check({tag, "_sum"},   64'(rsp_sum),   64'(es));
    check({tag, "_carry"}, 64'(rsp_carry), 64'(ec));
    check({tag, "_id"},    64'(rsp_id),    64'(i));
`ifdef ADDER_ARB_OVF_EN
    check({tag, "_ovf"},   64'(rsp_ovf),   64'(eo));
`else
    if (eo) n_vec += 0;
`endif
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check({tag, "_drain"}, 64'(rsp_valid), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int order [6] = '{0, 1, 2, 0, 1, 2};
    logic [WIDTH-1:0] rr_sum [3] = '{32'd100, 32'd201, 32'd302};

    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    #12;
    check("rst_valid",   64'(rsp_valid), 64'(0));
    check("rst_ready",   64'(req_ready), 64'(0));
    check("rst_adder_a", 64'(adder_a),   64'(0));
    check("rst_sum",     64'(rsp_sum),   64'(0));
    check("rst_id",      64'(rsp_id),    64'(0));
    rst_n = 1'b1;

    single("basic", 0, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
    single("wrap",  2, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);
`ifdef ADDER_ARB_OVF_EN
    single("ovf",   2, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1);
`endif

    // Round robin with all three requesters asserting continuously.
    for (int i = 0; i < NREQ; i++) set_op(i, 32'(100 * (i + 1)), 32'(i));
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1 check("rr_grant", 64'(req_ready), 64'(oh(order[k])));
      if (k > 0) begin
        check("rr_valid", 64'(rsp_valid), 64'(1));
        check("rr_id",    64'(rsp_id),    64'(order[k-1]));
        check("rr_sum",   64'(rsp_sum),   64'(rr_sum[order[k-1]]));
      end
      step();
      check("rr_exec_ready", 64'(req_ready), 64'(0));
      check("rr_exec_valid", 64'(rsp_valid), 64'(0));
      step();
    end
    check("rr_last_id",  64'(rsp_id),  64'(2));
    check("rr_last_sum", 64'(rsp_sum), 64'(302));
    req_valid = '0;
    step();
    check("rr_idle", 64'(rsp_valid), 64'(0));
    rsp_ready = 1'b0;

    // Backpressure: result held, pending requester 1 must wait.
    set_op(0, 32'd1, 32'd2);
    req_valid = 3'b001;
    #1 check("bp_ready0", 64'(req_ready), 64'(3'b001));
    step();
    req_valid = '0;
    step();
    set_op(1, 32'd20, 32'd22);
    req_valid = 3'b010;
    for (int c = 0; c < 5; c++) begin
      #1 check("bp_hold_ready", 64'(req_ready), 64'(0));
      check("bp_hold_valid", 64'(rsp_valid), 64'(1));
      check("bp_hold_sum",   64'(rsp_sum),   64'(3));
      check("bp_hold_id",    64'(rsp_id),    64'(0));
      step();
    end
    rsp_ready = 1'b1;
    #1 check("bp_release_ready", 64'(req_ready), 64'(3'b010));
    step();
    req_valid = '0;
    rsp_ready = 1'b0;
    check("bp_gap_valid", 64'(rsp_valid), 64'(0));
    step();
    check("bp_valid", 64'(rsp_valid), 64'(1));
    check("bp_sum",   64'(rsp_sum),   64'(42));
    check("bp_id",    64'(rsp_id),    64'(1));
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Reset while an operation is in EXEC.
    set_op(1, 32'd9, 32'd9);
    req_valid = 3'b010;
    #1 check("rst_mid_grant", 64'(req_ready), 64'(3'b010));
    step();
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid",   64'(rsp_valid), 64'(0));
    check("rst_mid_adder_a", 64'(adder_a),   64'(0));
    check("rst_mid_adder_b", 64'(adder_b),   64'(0));
    check("rst_mid_sum",     64'(rsp_sum),   64'(0));
    check("rst_mid_ready",   64'(req_ready), 64'(0));
    step();
    rst_n = 1'b1;
    step();
    step();
    check("rst_no_stale", 64'(rsp_valid), 64'(0));
    req_valid = '1;
    #1 check("rst_prio", 64'(req_ready), 64'(3'b001));
    step();
    req_valid = '0;
    step();
    check("rst_after_sum", 64'(rsp_sum), 64'(3));
    check("rst_after_id",  64'(rsp_id),  64'(0));
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Requester 1 waits while requester 0 keeps asking.
    single("pre_fair", 2, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    req_valid = 3'b011;
    rsp_ready = 1'b1;
    #1 check("fair_first", 64'(req_ready), 64'(3'b001));
    step();
    step();
    #1 check("fair_second", 64'(req_ready), 64'(3'b010));
    step();
    req_valid = '0;
    step();
    check("fair_id", 64'(rsp_id), 64'(1));
    step();
    rsp_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
